// File: rtl/cfg_regs_pkg.sv
// Shared definitions for the PWM/output configuration register file:
// address map, bus widths and the write-request payload.
package cfg_regs_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned NUM_REGS = 5;

    localparam logic [ADDR_W-1:0] ADDR_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'd4;

    // One register write: address plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // True for an address that maps onto an implemented register.
    function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/cfg_write_scheduler_if.sv
// Write-port bundle for the config write scheduler.
// Carries the host (SPI-side) and sequencer valid/ready/addr/data handshakes.
//   master : requester side (drives valid/addr/data, receives ready)
//   slave  : scheduler side
interface cfg_write_scheduler_if
    import cfg_regs_pkg::*;
    ();

    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;

    logic              seq_valid;
    logic              seq_ready;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_data;

    modport master (
        output host_valid, host_addr, host_data,
        output seq_valid, seq_addr, seq_data,
        input  host_ready, seq_ready
    );

    modport slave (
        input  host_valid, host_addr, host_data,
        input  seq_valid, seq_addr, seq_data,
        output host_ready, seq_ready
    );

endinterface

// File: rtl/cfg_write_arbiter.sv
// Two-port write arbiter: host has priority, but after STARVE_LIMIT
// consecutive host grants with seq waiting, seq is forced a grant.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   host_valid/host_req   host request and payload
//   seq_valid/seq_req     sequencer request and payload
//   host_gnt_c/seq_gnt_c  combinational grants (used as ready)
//   wr_en_c/wr_req_c      combinational write strobe and selected payload
module cfg_write_arbiter
    import cfg_regs_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    host_valid,
    input  wr_req_t host_req,
    input  logic    seq_valid,
    input  wr_req_t seq_req,
    output logic    host_gnt_c,
    output logic    seq_gnt_c,
    output logic    wr_en_c,
    output wr_req_t wr_req_c
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved_c;

    // Grant selection and starvation counter update.
    always_comb begin
        starved_c    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        seq_gnt_c    = seq_valid && (!host_valid || starved_c);
        host_gnt_c   = host_valid && !seq_gnt_c;
        wr_en_c      = host_gnt_c || seq_gnt_c;
        wr_req_c     = seq_gnt_c ? seq_req : host_req;
        starve_cnt_d = starve_cnt_q;
        if (!seq_valid || seq_gnt_c) begin
            starve_cnt_d = '0;
        end else if (host_gnt_c && !starved_c) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/cfg_write_scheduler.sv
// PWM/output configuration register file with scheduled writes.
// Output-enable registers update immediately; PWM registers are staged in
// shadows and committed together on pwm_period_start.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_if (slave)       host/seq write handshakes
//   pwm_period_start    one-cycle pulse at each PWM period start
//   en_reg_*            live register copies (addr 0..3)
//   pwm_duty_cycle      live duty cycle (addr 4)
//   commit_pending      some shadow holds an uncommitted value
//   wr_err              pulse after an accepted write to an unmapped addr
module cfg_write_scheduler
    import cfg_regs_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          SHADOW_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    cfg_write_scheduler_if.slave wr_if,
    input  logic              pwm_period_start,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              commit_pending,
    output logic              wr_err
);

    wr_req_t host_req;
    wr_req_t seq_req;
    wr_req_t wr_req_c;
    logic    wr_en_c;
    logic    host_gnt_c;
    logic    seq_gnt_c;

    assign host_req = '{addr: wr_if.host_addr, data: wr_if.host_data};
    assign seq_req  = '{addr: wr_if.seq_addr,  data: wr_if.seq_data};

    cfg_write_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (wr_if.host_valid),
        .host_req   (host_req),
        .seq_valid  (wr_if.seq_valid),
        .seq_req    (seq_req),
        .host_gnt_c (host_gnt_c),
        .seq_gnt_c  (seq_gnt_c),
        .wr_en_c    (wr_en_c),
        .wr_req_c   (wr_req_c)
    );

    assign wr_if.host_ready = host_gnt_c;
    assign wr_if.seq_ready  = seq_gnt_c;

    // Live registers, shadows (bit 0 = pwm_lo, 1 = pwm_hi, 2 = duty) and dirty bits.
    logic [DATA_W-1:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
    logic [DATA_W-1:0] out_lo_d, out_hi_d, pwm_lo_d, pwm_hi_d, duty_d;
    logic [DATA_W-1:0] sh_lo_q, sh_hi_q, sh_duty_q;
    logic [DATA_W-1:0] sh_lo_d, sh_hi_d, sh_duty_d;
    logic [2:0]        dirty_q, dirty_d;
    logic              pending_q, err_q, err_d;

    // Commit first from pre-edge shadows, then apply the granted write so a
    // write coinciding with a commit lands in its shadow and stays dirty.
    always_comb begin
        out_lo_d  = out_lo_q;
        out_hi_d  = out_hi_q;
        pwm_lo_d  = pwm_lo_q;
        pwm_hi_d  = pwm_hi_q;
        duty_d    = duty_q;
        sh_lo_d   = sh_lo_q;
        sh_hi_d   = sh_hi_q;
        sh_duty_d = sh_duty_q;
        dirty_d   = dirty_q;
        err_d     = wr_en_c && !addr_in_map(wr_req_c.addr);

        if (pwm_period_start) begin
            if (dirty_q[0]) pwm_lo_d = sh_lo_q;
            if (dirty_q[1]) pwm_hi_d = sh_hi_q;
            if (dirty_q[2]) duty_d   = sh_duty_q;
            dirty_d = '0;
        end

        if (wr_en_c) begin
            case (wr_req_c.addr)
                ADDR_OUT_LO: out_lo_d = wr_req_c.data;
                ADDR_OUT_HI: out_hi_d = wr_req_c.data;
                ADDR_PWM_LO: begin
                    if (SHADOW_EN) begin
                        sh_lo_d    = wr_req_c.data;
                        dirty_d[0] = 1'b1;
                    end else begin
                        pwm_lo_d = wr_req_c.data;
                    end
                end
                ADDR_PWM_HI: begin
                    if (SHADOW_EN) begin
                        sh_hi_d    = wr_req_c.data;
                        dirty_d[1] = 1'b1;
                    end else begin
                        pwm_hi_d = wr_req_c.data;
                    end
                end
                ADDR_DUTY: begin
                    if (SHADOW_EN) begin
                        sh_duty_d  = wr_req_c.data;
                        dirty_d[2] = 1'b1;
                    end else begin
                        duty_d = wr_req_c.data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q  <= '0;
            out_hi_q  <= '0;
            pwm_lo_q  <= '0;
            pwm_hi_q  <= '0;
            duty_q    <= '0;
            sh_lo_q   <= '0;
            sh_hi_q   <= '0;
            sh_duty_q <= '0;
            dirty_q   <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            out_lo_q  <= out_lo_d;
            out_hi_q  <= out_hi_d;
            pwm_lo_q  <= pwm_lo_d;
            pwm_hi_q  <= pwm_hi_d;
            duty_q    <= duty_d;
            sh_lo_q   <= sh_lo_d;
            sh_hi_q   <= sh_hi_d;
            sh_duty_q <= sh_duty_d;
            dirty_q   <= dirty_d;
            pending_q <= |dirty_d;
            err_q     <= err_d;
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign commit_pending  = pending_q;
    assign wr_err          = err_q;

endmodule

// File: tb/tb_cfg_write_scheduler.sv
// Self-checking bench for cfg_write_scheduler: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences.
module tb_cfg_write_scheduler;
    import cfg_regs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pps;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       pend, err;

    int n_tests = 0;
    int n_fail  = 0;

    cfg_write_scheduler_if wr_if ();

    cfg_write_scheduler #(
        .STARVE_LIMIT (4),
        .SHADOW_EN    (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_if            (wr_if),
        .pwm_period_start (pps),
        .en_reg_out_7_0   (out_lo),
        .en_reg_out_15_8  (out_hi),
        .en_reg_pwm_7_0   (pwm_lo),
        .en_reg_pwm_15_8  (pwm_hi),
        .pwm_duty_cycle   (duty),
        .commit_pending   (pend),
        .wr_err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hv;
        logic [6:0] ha;
        logic [7:0] hd;
        logic       sv;
        logic [6:0] sa;
        logic [7:0] sd;
        logic       pps;
        logic       ehr;
        logic       esr;
        logic [7:0] e_olo;
        logic [7:0] e_ohi;
        logic [7:0] e_plo;
        logic [7:0] e_phi;
        logic [7:0] e_duty;
        logic       e_pend;
        logic       e_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic hv, input logic [6:0] ha, input logic [7:0] hd,
                         input logic sv, input logic [6:0] sa, input logic [7:0] sd,
                         input logic p);
        wr_if.host_valid = hv;
        wr_if.host_addr  = ha;
        wr_if.host_data  = hd;
        wr_if.seq_valid  = sv;
        wr_if.seq_addr   = sa;
        wr_if.seq_data   = sd;
        pps              = p;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 8'd0, 1'b0, 7'd0, 8'd0, 1'b0);
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] olo, input logic [7:0] ohi,
                            input logic [7:0] plo, input logic [7:0] phi, input logic [7:0] dty,
                            input logic pe, input logic er);
        chk({tag, ".out_lo"}, 32'(out_lo), 32'(olo));
        chk({tag, ".out_hi"}, 32'(out_hi), 32'(ohi));
        chk({tag, ".pwm_lo"}, 32'(pwm_lo), 32'(plo));
        chk({tag, ".pwm_hi"}, 32'(pwm_hi), 32'(phi));
        chk({tag, ".duty"},   32'(duty),   32'(dty));
        chk({tag, ".pending"}, 32'(pend),  32'(pe));
        chk({tag, ".wr_err"},  32'(err),   32'(er));
    endtask

    task automatic chk_ready(input string tag, input logic hr, input logic sr);
        chk({tag, ".host_ready"}, 32'(wr_if.host_ready), 32'(hr));
        chk({tag, ".seq_ready"},  32'(wr_if.seq_ready),  32'(sr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //               hv  ha      hd     sv  sa      sd     pps ehr esr olo    ohi    plo    phi    duty   pend err
        vecs[0]  = '{1'b1, 7'h00, 8'hA5, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h01, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 7'h7F, 8'h55, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 7'h02, 8'h11, 1'b1, 7'h03, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h03, 8'h22, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h80, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h11, 8'h22, 8'h80, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 7'h00, 8'h00, 1'b1, 7'h05, 8'h99, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h11, 8'h22, 8'h80, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 7'h02, 8'h01, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h11, 8'h22, 8'h80, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 7'h02, 8'h02, 1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h11, 8'h22, 8'h80, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h02, 8'h22, 8'h80, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 7'h04, 8'h5A, 1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h02, 8'h22, 8'h80, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h02, 8'h22, 8'h5A, 1'b0, 1'b0};

        // Reset state
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk_ready("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors: one cycle each, ready checked before the edge
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].hv, vecs[i].ha, vecs[i].hd, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].pps);
            #1;
            chk_ready($sformatf("vec%0d", i), vecs[i].ehr, vecs[i].esr);
            @(negedge clk);
            chk_regs($sformatf("vec%0d", i), vecs[i].e_olo, vecs[i].e_ohi, vecs[i].e_plo,
                     vecs[i].e_phi, vecs[i].e_duty, vecs[i].e_pend, vecs[i].e_err);
        end
        idle();

        // Duty write held in shadow for 10 cycles until the period boundary
        do_reset();
        drive(1'b1, 7'h04, 8'h80, 1'b0, 7'h00, 8'h00, 1'b0);
        @(negedge clk);
        idle();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d.duty", i), 32'(duty), 32'h00);
            chk($sformatf("hold%0d.pending", i), 32'(pend), 32'h1);
            @(negedge clk);
        end
        pps = 1'b1;
        @(negedge clk);
        pps = 1'b0;
        chk("commit.duty", 32'(duty), 32'h80);
        chk("commit.pending", 32'(pend), 32'h0);

        // Starvation: both valid continuously -> H,H,H,H,S repeating
        begin
            int seq_grants = 0;
            for (int i = 0; i < 15; i++) begin
                drive(1'b1, 7'h00, 8'(i), 1'b1, 7'h01, 8'hC3, 1'b0);
                #1;
                chk_ready($sformatf("starve%0d", i), (i % 5) != 4, (i % 5) == 4);
                if (wr_if.seq_ready) seq_grants++;
                @(negedge clk);
            end
            chk("starve.seq_grants", 32'(seq_grants), 32'd3);
            chk("starve.out_lo", 32'(out_lo), 32'd13);
            chk("starve.out_hi", 32'(out_hi), 32'hC3);
        end
        idle();
        @(negedge clk);

        // Write coinciding with a commit is deferred to the next boundary
        drive(1'b1, 7'h03, 8'h33, 1'b0, 7'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("coin.pre_phi", 32'(pwm_hi), 32'h00);
        drive(1'b0, 7'h00, 8'h00, 1'b1, 7'h02, 8'h0F, 1'b1);
        #1;
        chk_ready("coin", 1'b0, 1'b1);
        @(negedge clk);
        idle();
        chk("coin.phi", 32'(pwm_hi), 32'h33);
        chk("coin.plo", 32'(pwm_lo), 32'h00);
        chk("coin.pending", 32'(pend), 32'h1);
        @(negedge clk);
        pps = 1'b1;
        @(negedge clk);
        pps = 1'b0;
        chk("coin2.plo", 32'(pwm_lo), 32'h0F);
        chk("coin2.phi", 32'(pwm_hi), 32'h33);
        chk("coin2.pending", 32'(pend), 32'h0);

        // Reset mid-operation discards the pending shadow
        drive(1'b1, 7'h04, 8'h40, 1'b0, 7'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst.pre_pending", 32'(pend), 32'h1);
        drive(1'b1, 7'h04, 8'h41, 1'b0, 7'h00, 8'h00, 1'b0);
        #1;
        chk_ready("rst.mid", 1'b1, 1'b0);
        #1;
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_regs("rst.hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        pps = 1'b1;
        @(negedge clk);
        pps = 1'b0;
        chk("rst.post_duty", 32'(duty), 32'h00);
        chk("rst.post_pending", 32'(pend), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
